// File: rtl/calc_entry_ctrl_if.sv
// Keypad / calculator handshake bundle for calc_entry_ctrl.
//   master : keypad + calculator side (drives key strobe, key code, calculator result)
//   slave  : entry controller (drives operand digits, phase, operation, ready, display)
// Signal names follow the calculator datapath pin names (A1..A4, B1..B4, ST, ST_L).
interface calc_entry_ctrl_if;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;
  logic [15:0] number;
  logic [3:0]  A1, A2, A3, A4;
  logic [3:0]  B1, B2, B3, B4;
  logic [1:0]  ST;
  logic [2:0]  ST_L;
  logic [15:0] disp;

  modport master (
    output key_valid, key_code, number,
    input  key_ready, A1, A2, A3, A4, B1, B2, B3, B4, ST, ST_L, disp
  );

  modport slave (
    input  key_valid, key_code, number,
    output key_ready, A1, A2, A3, A4, B1, B2, B3, B4, ST, ST_L, disp
  );
endinterface

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad-driven sequencer for the 4-digit BCD calculator datapath.
// Collects operand A digits, an operator and operand B digits from a one-cycle key strobe,
// holds the calculator in S_OBL for one cycle, latches its result and selects the display.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   bus_io  calc_entry_ctrl_if.slave
//             in : key_valid, key_code[4:0], number[15:0]
//             out: A1..A4, B1..B4 (A1/B1 least significant), ST[1:0], ST_L[2:0],
//                  key_ready (combinational from ST), disp[15:0] (combinational from ST)
//
// Build option: define CALC_CHAIN_EN so an operator in S_RES chains the result into A.
module calc_entry_ctrl (
  input  logic                clk,
  input  logic                rst,
  calc_entry_ctrl_if.slave    bus_io
);

  typedef enum logic [1:0] {
    StA   = 2'd0,
    StB   = 2'd1,
    StObl = 2'd2,
    StRes = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpXor = 3'd2,
    OpAnd = 3'd3,
    OpOr  = 3'd4
  } op_e;

  localparam logic [4:0] KeyAdd = 5'h10;
  localparam logic [4:0] KeyOr  = 5'h14;
  localparam logic [4:0] KeyEq  = 5'h15;
  localparam logic [4:0] KeyClr = 5'h16;

  state_e      st_q, st_d;
  op_e         st_l_q, st_l_d;
  logic [15:0] a_q, a_d;        // {A4,A3,A2,A1}
  logic [15:0] b_q, b_d;        // {B4,B3,B2,B1}
  logic [2:0]  a_cnt_q, a_cnt_d;
  logic [2:0]  b_cnt_q, b_cnt_d;
  logic [15:0] result_q, result_d;

  logic        key_acc;
  logic        is_digit;
  logic        is_op;
  logic [3:0]  digit;
  op_e         key_op;

  // Keys are only refused while the calculator is being sampled.
  assign key_acc  = bus_io.key_valid && (st_q != StObl);
  assign is_digit = (bus_io.key_code <= 5'd9);
  assign is_op    = (bus_io.key_code >= KeyAdd) && (bus_io.key_code <= KeyOr);
  assign digit    = bus_io.key_code[3:0];
  // Operator codes 0x10..0x14 map directly onto the low three bits.
  assign key_op   = op_e'(bus_io.key_code[2:0]);

  always_comb begin
    st_d     = st_q;
    st_l_d   = st_l_q;
    a_d      = a_q;
    b_d      = b_q;
    a_cnt_d  = a_cnt_q;
    b_cnt_d  = b_cnt_q;
    result_d = result_q;

    if (st_q == StObl) begin
      // Single sample cycle; any key strobe, including CLEAR, is lost here.
      result_d = bus_io.number;
      st_d     = StRes;
    end else if (key_acc) begin
      if (bus_io.key_code == KeyClr) begin
        st_d     = StA;
        st_l_d   = OpAdd;
        a_d      = '0;
        b_d      = '0;
        a_cnt_d  = '0;
        b_cnt_d  = '0;
        result_d = '0;
      end else if (is_digit) begin
        unique case (st_q)
          StA: begin
            if (a_cnt_q != 3'd4) begin
              a_d     = {a_q[11:0], digit};
              a_cnt_d = a_cnt_q + 3'd1;
            end
          end
          StB: begin
            if (b_cnt_q != 3'd4) begin
              b_d     = {b_q[11:0], digit};
              b_cnt_d = b_cnt_q + 3'd1;
            end
          end
          StRes: begin
            // A digit after a result starts a fresh calculation.
            a_d     = {12'h000, digit};
            a_cnt_d = 3'd1;
            b_d     = '0;
            b_cnt_d = '0;
            st_l_d  = OpAdd;
            st_d    = StA;
          end
          default: ;
        endcase
      end else if (is_op) begin
        unique case (st_q)
          StA: begin
            st_l_d  = key_op;
            b_d     = '0;
            b_cnt_d = '0;
            st_d    = StB;
          end
          StB: begin
            // Operator may be changed only before any B digit is typed.
            if (b_cnt_q == 3'd0) begin
              st_l_d = key_op;
            end
          end
          StRes: begin
`ifdef CALC_CHAIN_EN
            a_d     = result_q;
            a_cnt_d = 3'd4;
            st_l_d  = key_op;
            b_d     = '0;
            b_cnt_d = '0;
            st_d    = StB;
`else
            st_d    = StRes;
`endif
          end
          default: ;
        endcase
      end else if (bus_io.key_code == KeyEq) begin
        if (st_q == StB) begin
          st_d = StObl;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= StA;
      st_l_q   <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
      result_q <= '0;
    end else begin
      st_q     <= st_d;
      st_l_q   <= st_l_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_cnt_q  <= a_cnt_d;
      b_cnt_q  <= b_cnt_d;
      result_q <= result_d;
    end
  end

  assign bus_io.A1        = a_q[3:0];
  assign bus_io.A2        = a_q[7:4];
  assign bus_io.A3        = a_q[11:8];
  assign bus_io.A4        = a_q[15:12];
  assign bus_io.B1        = b_q[3:0];
  assign bus_io.B2        = b_q[7:4];
  assign bus_io.B3        = b_q[11:8];
  assign bus_io.B4        = b_q[15:12];
  assign bus_io.ST        = st_q;
  assign bus_io.ST_L      = st_l_q;
  assign bus_io.key_ready = (st_q != StObl);

  always_comb begin
    bus_io.disp = a_q;
    unique case (st_q)
      StA, StObl: bus_io.disp = a_q;
      StB:        bus_io.disp = b_q;
      StRes:      bus_io.disp = result_q;
      default:    bus_io.disp = a_q;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed scenarios followed by random key traffic,
// all compared against a digit-list reference model of the keypad calculator.
module tb_calc_entry_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_entry_ctrl_if bus_if ();

  calc_entry_ctrl u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=enter A, 1=enter B, 2=busy, 3=showing result.
  int m_phase = 0;
  int m_op    = 0;
  int m_res   = 0;
  int m_qa[$];
  int m_qb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int a_val();
    int v = 0;
    foreach (m_qa[i]) v = v * 16 + m_qa[i];
    return v;
  endfunction

  function automatic int b_val();
    int v = 0;
    foreach (m_qb[i]) v = v * 16 + m_qb[i];
    return v;
  endfunction

  task automatic model_clear();
    m_phase = 0;
    m_op    = 0;
    m_res   = 0;
    m_qa.delete();
    m_qb.delete();
  endtask

  task automatic model_step(input bit r, input bit kv, input int kc, input int num);
    if (r) begin
      model_clear();
    end else if (m_phase == 2) begin
      m_res   = num;
      m_phase = 3;
    end else if (kv) begin
      if (kc == 'h16) begin
        model_clear();
      end else if (kc <= 9) begin
        if (m_phase == 0 && m_qa.size() < 4) m_qa.push_back(kc);
        else if (m_phase == 1 && m_qb.size() < 4) m_qb.push_back(kc);
        else if (m_phase == 3) begin
          m_qa.delete();
          m_qb.delete();
          m_qa.push_back(kc);
          m_op    = 0;
          m_phase = 0;
        end
      end else if (kc >= 'h10 && kc <= 'h14) begin
        if (m_phase == 0) begin
          m_op = kc - 'h10;
          m_qb.delete();
          m_phase = 1;
        end else if (m_phase == 1 && m_qb.size() == 0) begin
          m_op = kc - 'h10;
        end else if (m_phase == 3) begin
`ifdef CALC_CHAIN_EN
          m_qa.delete();
          for (int i = 3; i >= 0; i--) m_qa.push_back((m_res >> (4 * i)) & 'hF);
          m_qb.delete();
          m_op    = kc - 'h10;
          m_phase = 1;
`endif
        end
      end else if (kc == 'h15 && m_phase == 1) begin
        m_phase = 2;
      end
    end
  endtask

  function automatic logic [15:0] dut_a();
    return {bus_if.A4, bus_if.A3, bus_if.A2, bus_if.A1};
  endfunction

  function automatic logic [15:0] dut_b();
    return {bus_if.B4, bus_if.B3, bus_if.B2, bus_if.B1};
  endfunction

  task automatic check_all();
    int exp_disp;
    exp_disp = (m_phase == 1) ? b_val() : (m_phase == 3) ? m_res : a_val();
    check_eq("st",        32'(bus_if.ST),        32'(m_phase));
    check_eq("st_l",      32'(bus_if.ST_L),      32'(m_op));
    check_eq("a",         32'(dut_a()),          32'(a_val()));
    check_eq("b",         32'(dut_b()),          32'(b_val()));
    check_eq("key_ready", 32'(bus_if.key_ready), 32'(m_phase != 2));
    check_eq("disp",      32'(bus_if.disp),      32'(exp_disp));
  endtask

  // Drive one cycle of inputs, advance the model, then compare just after the edge.
  task automatic step(input bit r, input bit kv, input logic [4:0] kc, input logic [15:0] num);
    rst              = r;
    bus_if.key_valid = kv;
    bus_if.key_code  = kc;
    bus_if.number    = num;
    model_step(r, kv, int'(kc), int'(num));
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic key(input logic [4:0] kc);
    step(1'b0, 1'b1, kc, 16'($urandom));
  endtask

  task automatic idle(input logic [15:0] num);
    step(1'b0, 1'b0, 5'h00, num);
  endtask

  initial begin
    bus_if.key_valid = 1'b0;
    bus_if.key_code  = '0;
    bus_if.number    = '0;

    step(1'b1, 1'b0, 5'h00, 16'h0);
    step(1'b1, 1'b0, 5'h00, 16'h0);

    // Reset mid-entry
    key(5'd1); key(5'd2);
    check_eq("mid_a", 32'(dut_a()), 32'h0012);
    step(1'b1, 1'b1, 5'd3, 16'h0);
    check_eq("rst_st",   32'(bus_if.ST),   32'd0);
    check_eq("rst_disp", 32'(bus_if.disp), 32'h0000);
    check_eq("rst_a",    32'(dut_a()),     32'h0000);

    // Addition 12 + 3
    key(5'd1);  check_eq("add_st0", 32'(bus_if.ST), 32'd0);
    key(5'd2);  check_eq("add_st1", 32'(bus_if.ST), 32'd0);
    key(5'h10); check_eq("add_st2", 32'(bus_if.ST), 32'd1);
    key(5'd3);  check_eq("add_b1",  32'(bus_if.B1), 32'd3);
    key(5'h15); check_eq("add_st4", 32'(bus_if.ST), 32'd2);
    idle(16'h0015);
    check_eq("add_st5",  32'(bus_if.ST),   32'd3);
    check_eq("add_stl",  32'(bus_if.ST_L), 32'd0);
    check_eq("add_disp", 32'(bus_if.disp), 32'h0015);

    // Digit overflow
    key(5'h16);
    key(5'd9); key(5'd8); key(5'd7); key(5'd6); key(5'd5);
    check_eq("ovf_a", 32'(dut_a()), 32'h9876);

    // Operator replacement, then the digit right after EQUALS is lost
    key(5'h16);
    key(5'd4); key(5'h10); key(5'h12);
    check_eq("repl_stl", 32'(bus_if.ST_L), 32'd2);
    check_eq("repl_st",  32'(bus_if.ST),   32'd1);
    key(5'h15);
    check_eq("busy_rdy", 32'(bus_if.key_ready), 32'd0);
    step(1'b0, 1'b1, 5'd7, 16'hBEEF);
    check_eq("busy_res", 32'(bus_if.disp), 32'hBEEF);
    check_eq("busy_a",   32'(dut_a()),     32'h0004);

    // Result exits: digit, then CLEAR
    key(5'd7);
    check_eq("rx_st", 32'(bus_if.ST),   32'd0);
    check_eq("rx_a",  32'(dut_a()),     32'h0007);
    check_eq("rx_op", 32'(bus_if.ST_L), 32'd0);
    key(5'h10); key(5'h15); idle(16'h1234);
    key(5'h16);
    check_eq("clr_st",   32'(bus_if.ST),   32'd0);
    check_eq("clr_disp", 32'(bus_if.disp), 32'h0000);

    // Reset during the busy cycle must not capture the result
    key(5'd5); key(5'h11); key(5'h15);
    step(1'b1, 1'b0, 5'h00, 16'h7777);
    check_eq("rbusy_st", 32'(bus_if.ST), 32'd0);

    // Chaining from result 0x0042
    key(5'd4); key(5'h10); key(5'd2); key(5'h15); idle(16'h0042);
    key(5'h11);
`ifdef CALC_CHAIN_EN
    check_eq("chain_a",  32'(dut_a()),     32'h0042);
    check_eq("chain_op", 32'(bus_if.ST_L), 32'd1);
    check_eq("chain_st", 32'(bus_if.ST),   32'd1);
`else
    check_eq("nochain_st", 32'(bus_if.ST), 32'd3);
`endif

    // Random key traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [4:0] kc;
      sel = int'($urandom_range(0, 99));
      if (sel < 50)      kc = 5'($urandom_range(0, 9));
      else if (sel < 68) kc = 5'($urandom_range(16, 20));
      else if (sel < 82) kc = 5'h15;
      else if (sel < 85) kc = 5'h16;
      else if (sel < 92) kc = 5'($urandom_range(10, 15));
      else               kc = 5'($urandom_range(23, 31));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), kc, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
